// File: rtl/psum_collector.sv
// Collects NUM_PASSES psum beats from the PE array columns, sums each lane with
// saturation, and presents the result until the consumer accepts it.
module psum_collector #(
    parameter int unsigned PE_WIDTH   = 4,
    parameter int unsigned NUM_COLS   = 3,
    parameter int unsigned ACC_WIDTH  = 6,
    parameter int unsigned NUM_PASSES = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [PE_WIDTH*NUM_COLS-1:0]         psum_in_flat,
    input  logic                                 psum_valid,
    input  logic                                 out_ready,
    output logic [ACC_WIDTH*NUM_COLS-1:0]        out_data_flat,
    output logic                                 out_valid,
    output logic                                 busy,
    output logic [$clog2(NUM_PASSES+1)-1:0]      pass_cnt,
    output logic                                 sat_flag,
    output logic                                 err_drop
);

    localparam int unsigned CNT_W  = $clog2(NUM_PASSES + 1);
    localparam int unsigned DATA_W = ACC_WIDTH * NUM_COLS;
    localparam int unsigned SUM_W  = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                sat_q, sat_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   acc_sum;
    logic [NUM_COLS-1:0] lane_sat;
    logic [SUM_W-1:0]    lane_raw;
    logic                last_beat;

    // Per-lane add with one carry bit; the carry marks a lane that must clamp.
    always_comb begin
        acc_sum  = '0;
        lane_sat = '0;
        lane_raw = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            lane_raw = SUM_W'(acc_q[c*ACC_WIDTH +: ACC_WIDTH])
                     + SUM_W'(psum_in_flat[c*PE_WIDTH +: PE_WIDTH]);
            if (lane_raw[ACC_WIDTH]) begin
                acc_sum[c*ACC_WIDTH +: ACC_WIDTH] = '1;
                lane_sat[c]                        = 1'b1;
            end else begin
                acc_sum[c*ACC_WIDTH +: ACC_WIDTH] = lane_raw[ACC_WIDTH-1:0];
            end
        end
    end

    assign last_beat = (cnt_q == CNT_W'(NUM_PASSES - 1));

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (psum_valid) begin
                    err_d = 1'b1;
                end
                // A beat arriving together with start is dropped but still flagged.
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    err_d   = psum_valid;
                end
            end

            ACCUM: begin
                if (psum_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (|lane_sat) begin
                        sat_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d     = DRAIN;
                        out_valid_d = 1'b1;
                        out_data_d  = acc_sum;
                    end
                end
            end

            DRAIN: begin
                if (psum_valid) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_data_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
        end
    end

    assign out_data_flat = out_data_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign pass_cnt      = cnt_q;
    assign sat_flag      = sat_q;
    assign err_drop      = err_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: accumulation, saturation, back-pressure,
// dropped beats, mid-run reset and ignored start.
module tb_psum_collector;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] psum_in_flat;
    logic        psum_valid;
    logic        out_ready;
    logic [17:0] out_data_flat;
    logic        out_valid;
    logic        busy;
    logic [2:0]  pass_cnt;
    logic        sat_flag;
    logic        err_drop;

    int n_vec;
    int n_mis;

    psum_collector #(
        .PE_WIDTH  (4),
        .NUM_COLS  (3),
        .ACC_WIDTH (6),
        .NUM_PASSES(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .psum_in_flat (psum_in_flat),
        .psum_valid   (psum_valid),
        .out_ready    (out_ready),
        .out_data_flat(out_data_flat),
        .out_valid    (out_valid),
        .busy         (busy),
        .pass_cnt     (pass_cnt),
        .sat_flag     (sat_flag),
        .err_drop     (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input int n, input logic [3:0] l0, input logic [3:0] l1, input logic [3:0] l2);
        for (int i = 0; i < n; i++) begin
            psum_in_flat = {l2, l1, l0};
            psum_valid   = 1'b1;
            step();
        end
        psum_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_cnt"},   32'(pass_cnt),  32'd0);
        chk({tag, "_data"},  32'(out_data_flat), 32'd0);
        chk({tag, "_sat"},   32'(sat_flag),  32'd0);
        chk({tag, "_err"},   32'(err_drop),  32'd0);
    endtask

    initial begin
        n_vec        = 0;
        n_mis        = 0;
        rst          = 1'b0;
        start        = 1'b0;
        psum_in_flat = '0;
        psum_valid   = 1'b0;
        out_ready    = 1'b0;

        step();
        chk_zero("reset");
        step();
        rst = 1'b1;
        step();

        // Basic accumulation 1/2/3 over five beats
        do_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cnt",  32'(pass_cnt), 32'd0);
        beats(4, 4'd1, 4'd2, 4'd3);
        chk("b4_cnt",   32'(pass_cnt),  32'd4);
        chk("b4_valid", 32'(out_valid), 32'd0);
        chk("b4_data",  32'(out_data_flat), 32'd0);
        beats(1, 4'd1, 4'd2, 4'd3);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data",  32'(out_data_flat), 32'({6'd15, 6'd10, 6'd5}));
        chk("basic_sat",   32'(sat_flag),  32'd0);
        chk("basic_cnt",   32'(pass_cnt),  32'd5);
        drain();
        chk("basic_done_valid", 32'(out_valid), 32'd0);
        chk("basic_done_busy",  32'(busy),      32'd0);
        chk("basic_done_data",  32'(out_data_flat), 32'd0);

        // Saturation on lane 0 only
        do_start();
        beats(5, 4'd15, 4'd1, 4'd1);
        chk("sat_valid", 32'(out_valid), 32'd1);
        chk("sat_data",  32'(out_data_flat), 32'({6'd5, 6'd5, 6'd63}));
        chk("sat_flag",  32'(sat_flag),  32'd1);

        // Back-pressure: result holds while out_ready is low
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data",  32'(out_data_flat), 32'({6'd5, 6'd5, 6'd63}));
            chk("hold_busy",  32'(busy), 32'd1);
        end
        drain();
        chk("hold_done_valid", 32'(out_valid), 32'd0);
        chk("hold_done_busy",  32'(busy),      32'd0);
        chk("sat_sticky",      32'(sat_flag),  32'd1);

        // Beat in IDLE is dropped and flagged until the next start
        beats(1, 4'd7, 4'd0, 4'd0);
        chk("idle_err",  32'(err_drop), 32'd1);
        chk("idle_busy", 32'(busy),     32'd0);
        step();
        chk("idle_err_hold", 32'(err_drop), 32'd1);
        do_start();
        chk("start_clr_err", 32'(err_drop), 32'd0);
        chk("start_clr_sat", 32'(sat_flag), 32'd0);
        beats(5, 4'd1, 4'd1, 4'd1);
        chk("drop_data", 32'(out_data_flat), 32'({6'd5, 6'd5, 6'd5}));
        chk("drop_err",  32'(err_drop), 32'd0);
        drain();

        // start together with a beat: accumulation starts, beat dropped
        start        = 1'b1;
        psum_in_flat = {4'd3, 4'd3, 4'd3};
        psum_valid   = 1'b1;
        step();
        start      = 1'b0;
        psum_valid = 1'b0;
        chk("sv_busy", 32'(busy),     32'd1);
        chk("sv_cnt",  32'(pass_cnt), 32'd0);
        chk("sv_err",  32'(err_drop), 32'd1);
        beats(5, 4'd1, 4'd2, 4'd1);
        chk("sv_data", 32'(out_data_flat), 32'({6'd5, 6'd10, 6'd5}));
        chk("sv_err_hold", 32'(err_drop), 32'd1);
        drain();

        // Reset in the middle of an accumulation
        do_start();
        beats(2, 4'd4, 4'd4, 4'd4);
        chk("pre_rst_cnt", 32'(pass_cnt), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        step();
        step();
        rst = 1'b1;
        do_start();
        beats(5, 4'd2, 4'd2, 4'd2);
        chk("post_rst_data", 32'(out_data_flat), 32'({6'd10, 6'd10, 6'd10}));
        chk("post_rst_sat",  32'(sat_flag), 32'd0);
        chk("post_rst_err",  32'(err_drop), 32'd0);
        drain();

        // start during ACCUM and DRAIN is ignored; a beat in DRAIN is flagged
        do_start();
        beats(2, 4'd3, 4'd1, 4'd2);
        start = 1'b1;
        step();
        chk("accum_start_cnt",  32'(pass_cnt), 32'd2);
        chk("accum_start_busy", 32'(busy),     32'd1);
        start = 1'b0;
        beats(3, 4'd3, 4'd1, 4'd2);
        chk("ign_valid", 32'(out_valid), 32'd1);
        chk("ign_data",  32'(out_data_flat), 32'({6'd10, 6'd5, 6'd15}));
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        chk("drain_start_cnt",  32'(pass_cnt), 32'd5);
        chk("drain_start_data", 32'(out_data_flat), 32'({6'd10, 6'd5, 6'd15}));
        chk("drain_err_pre",    32'(err_drop), 32'd0);
        beats(1, 4'd9, 4'd9, 4'd9);
        chk("drain_err",  32'(err_drop), 32'd1);
        chk("drain_data", 32'(out_data_flat), 32'({6'd10, 6'd5, 6'd15}));
        drain();
        chk("final_valid", 32'(out_valid), 32'd0);
        chk("final_busy",  32'(busy),      32'd0);
        chk("final_data",  32'(out_data_flat), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
